// File: rtl/memory_controller_if.sv
// rtl/memory_controller_if.sv - RAM port, IF fetch and LSB request signals of the memory controller
interface memory_controller_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;
    logic                  io_buffer_full;

    logic                  if_to_mc_ready;
    logic [ADDR_WIDTH-1:0] if_to_mc_PC;
    logic                  mc_to_if_valid;
    logic                  mc_to_if_ready;
    logic [31:0]           mc_to_if_inst;

    logic                  lsb_to_mc_ready;
    logic                  lsb_to_mc_wr;
    logic [1:0]            lsb_to_mc_len;
    logic [ADDR_WIDTH-1:0] lsb_to_mc_addr;
    logic [31:0]           lsb_to_mc_data;
    logic                  mc_to_lsb_valid;
    logic                  mc_to_lsb_ready;
    logic [31:0]           mc_to_lsb_data;

    modport master (
        input  mem_din, io_buffer_full,
        input  if_to_mc_ready, if_to_mc_PC,
        input  lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_len, lsb_to_mc_addr, lsb_to_mc_data,
        output mem_dout, mem_a, mem_wr,
        output mc_to_if_valid, mc_to_if_ready, mc_to_if_inst,
        output mc_to_lsb_valid, mc_to_lsb_ready, mc_to_lsb_data
    );

    modport slave (
        output mem_din, io_buffer_full,
        output if_to_mc_ready, if_to_mc_PC,
        output lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_len, lsb_to_mc_addr, lsb_to_mc_data,
        input  mem_dout, mem_a, mem_wr,
        input  mc_to_if_valid, mc_to_if_ready, mc_to_if_inst,
        input  mc_to_lsb_valid, mc_to_lsb_ready, mc_to_lsb_data
    );
endinterface

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte-serial unified RAM port controller, LSB-over-IF arbitration
module memory_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_SEL_HI  = 17
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic clr_in,
    memory_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, WAIT_IO} state_t;

    state_t                state_q, state_n;
    logic [2:0]            cnt_q, cnt_n;
    logic [2:0]            len_q, len_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [31:0]           wdata_q, wdata_n;
    logic [31:0]           rdata_q, rdata_n;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_n;
    logic [7:0]            dout_q, dout_n;
    logic                  wr_q, wr_n;
    logic                  if_valid_q, if_valid_n, if_ready_q, if_ready_n;
    logic                  lsb_valid_q, lsb_valid_n, lsb_ready_q, lsb_ready_n;
    logic [31:0]           inst_q, inst_n, ldata_q, ldata_n;
    logic                  paused_q;
    logic [7:0]            din_hold_q;

    logic [7:0] sample;
    logic [2:0] next_idx;
    logic [2:0] req_len;
    logic       req_io;

    // The RAM keeps answering while paused, so the byte due at the first frozen edge is kept aside.
    assign sample   = paused_q ? din_hold_q : bus.mem_din;
    assign next_idx = cnt_q + 3'd1;
    assign req_io   = (bus.lsb_to_mc_addr[IO_SEL_HI -: 2] == 2'b11);

    always_comb begin
        case (bus.lsb_to_mc_len)
            2'd0:    req_len = 3'd1;
            2'd1:    req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        len_n       = len_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        rdata_n     = rdata_q;
        mem_a_n     = mem_a_q;
        dout_n      = dout_q;
        wr_n        = 1'b0;
        if_valid_n  = 1'b0;
        if_ready_n  = 1'b0;
        lsb_valid_n = 1'b0;
        lsb_ready_n = 1'b0;
        inst_n      = inst_q;
        ldata_n     = ldata_q;
        case (state_q)
            IDLE: begin
                if (!clr_in && bus.lsb_to_mc_ready) begin
                    addr_n      = bus.lsb_to_mc_addr;
                    len_n       = req_len;
                    wdata_n     = bus.lsb_to_mc_data;
                    rdata_n     = 32'd0;
                    cnt_n       = 3'd0;
                    lsb_valid_n = 1'b1;
                    if (!bus.lsb_to_mc_wr) begin
                        state_n = LOAD;
                        mem_a_n = bus.lsb_to_mc_addr;
                    end else if (req_io && bus.io_buffer_full) begin
                        state_n = WAIT_IO;
                        mem_a_n = '0;
                    end else begin
                        state_n = STORE;
                        mem_a_n = bus.lsb_to_mc_addr;
                        dout_n  = bus.lsb_to_mc_data[7:0];
                        wr_n    = 1'b1;
                    end
                end else if (!clr_in && bus.if_to_mc_ready) begin
                    state_n    = IFETCH;
                    addr_n     = bus.if_to_mc_PC;
                    len_n      = 3'd4;
                    rdata_n    = 32'd0;
                    cnt_n      = 3'd0;
                    mem_a_n    = bus.if_to_mc_PC;
                    if_valid_n = 1'b1;
                end
            end
            IFETCH, LOAD: begin
                if (clr_in) begin
                    state_n = IDLE;
                    mem_a_n = '0;
                end else begin
                    // cnt_q counts edges since accept; byte cnt_q-1 is on mem_din now.
                    if (cnt_q != 3'd0)
                        rdata_n[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = sample;
                    if (cnt_q == len_q) begin
                        state_n = IDLE;
                        mem_a_n = '0;
                        if (state_q == IFETCH) begin
                            inst_n     = rdata_n;
                            if_ready_n = 1'b1;
                        end else begin
                            ldata_n     = rdata_n;
                            lsb_ready_n = 1'b1;
                        end
                    end else begin
                        cnt_n   = next_idx;
                        mem_a_n = (next_idx < len_q) ? addr_q + ADDR_WIDTH'(next_idx) : '0;
                    end
                end
            end
            STORE: begin
                if (next_idx < len_q) begin
                    cnt_n   = next_idx;
                    mem_a_n = addr_q + ADDR_WIDTH'(next_idx);
                    dout_n  = wdata_q[{next_idx[1:0], 3'b000} +: 8];
                    wr_n    = 1'b1;
                end else begin
                    state_n     = IDLE;
                    mem_a_n     = '0;
                    dout_n      = 8'd0;
                    lsb_ready_n = 1'b1;
                end
            end
            WAIT_IO: begin
                if (!bus.io_buffer_full) begin
                    state_n = STORE;
                    cnt_n   = 3'd0;
                    mem_a_n = addr_q;
                    dout_n  = wdata_q[7:0];
                    wr_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            mem_a_q     <= '0;
            dout_q      <= 8'd0;
            wr_q        <= 1'b0;
            if_valid_q  <= 1'b0;
            if_ready_q  <= 1'b0;
            lsb_valid_q <= 1'b0;
            lsb_ready_q <= 1'b0;
            inst_q      <= 32'd0;
            ldata_q     <= 32'd0;
            paused_q    <= 1'b0;
            din_hold_q  <= 8'd0;
        end else if (rdy_in) begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            len_q       <= len_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            rdata_q     <= rdata_n;
            mem_a_q     <= mem_a_n;
            dout_q      <= dout_n;
            wr_q        <= wr_n;
            if_valid_q  <= if_valid_n;
            if_ready_q  <= if_ready_n;
            lsb_valid_q <= lsb_valid_n;
            lsb_ready_q <= lsb_ready_n;
            inst_q      <= inst_n;
            ldata_q     <= ldata_n;
            paused_q    <= 1'b0;
        end else begin
            if (!paused_q)
                din_hold_q <= bus.mem_din;
            paused_q <= 1'b1;
        end
    end

    assign bus.mem_a           = mem_a_q;
    assign bus.mem_dout        = dout_q;
    assign bus.mem_wr          = wr_q & rdy_in;
    assign bus.mc_to_if_valid  = if_valid_q;
    assign bus.mc_to_if_ready  = if_ready_q;
    assign bus.mc_to_if_inst   = inst_q;
    assign bus.mc_to_lsb_valid = lsb_valid_q;
    assign bus.mc_to_lsb_ready = lsb_ready_q;
    assign bus.mc_to_lsb_data  = ldata_q;
endmodule
